// File: rtl/rcc_sched.sv
// rcc_sched: sequencer for the RC-timing sensor banks.
// It owns the poll timer, the charge phase, the sense window and the shared
// charge-time counter. Within one poll sweep it visits each enabled bank once,
// in ascending order. When a sweep finishes it raises data_avail.
//
// Interface semantics: every *_tick, cfg_we, rd_ack and bank_done is a
// single-cycle strobe sampled on a rising CLK_I edge. There is no backpressure.
// Each strobe is acted on in the cycle it is high and is then forgotten.
module rcc_sched #(
    parameter int NBANK = 4,
    parameter int CW    = 8,
    parameter int BW    = 2
) (
    input  logic             CLK_I,
    input  logic             RSTN_I,
    input  logic             m10_tick,
    input  logic             u10_tick,
    input  logic             cnt_tick,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_poll,
    input  logic [NBANK-1:0] cfg_bank_en,
    input  logic             cfg_early,
    input  logic             pins_done,
    input  logic             rd_ack,
    output logic [BW-1:0]    bank_sel,
    output logic             charge,
    output logic             sense,
    output logic [CW-1:0]    count,
    output logic             bank_done,
    output logic             busy,
    output logic             data_avail,
    output logic             overrun,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHARGE = 2'd1,
        SENSE  = 2'd2,
        NEXT   = 2'd3
    } state_t;

    state_t           state, state_d;
    logic [3:0]       poll_r;
    logic [NBANK-1:0] bank_en_r;
    logic             early_r;
    logic [3:0]       pollcount, pollcount_d;
    logic [NBANK-1:0] en_snap, en_snap_d;
    logic [BW-1:0]    bank_sel_d;
    logic [CW-1:0]    count_d;
    logic             chg_entry, chg_entry_d;  // first cycle of CHARGE: its u10_tick is ignored
    logic             u_seen, u_seen_d;        // one qualifying u10_tick already seen in CHARGE
    logic             sweep_end;
    logic [BW:0]      sel_hit;                 // {found, index}

    // Lowest set bit of v at index >= from; MSB of the result flags a hit.
    function automatic logic [BW:0] first_set(input logic [NBANK-1:0] v, input int from);
        logic [BW:0] r;
        r = '0;
        for (int i = NBANK - 1; i >= 0; i--) begin
            if (i >= from && v[i]) r = {1'b1, BW'(i)};
        end
        return r;
    endfunction

    // Host configuration registers; an active sweep keeps running on en_snap.
    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            poll_r    <= '0;
            bank_en_r <= '0;
            early_r   <= 1'b0;
        end else if (cfg_we) begin
            poll_r    <= cfg_poll;
            bank_en_r <= cfg_bank_en;
            early_r   <= cfg_early;
        end
    end

    // State register and sweep datapath registers.
    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            state     <= IDLE;
            bank_sel  <= '0;
            count     <= '0;
            pollcount <= 4'd1;
            en_snap   <= '0;
            chg_entry <= 1'b0;
            u_seen    <= 1'b0;
        end else begin
            state     <= state_d;
            bank_sel  <= bank_sel_d;
            count     <= count_d;
            pollcount <= pollcount_d;
            en_snap   <= en_snap_d;
            chg_entry <= chg_entry_d;
            u_seen    <= u_seen_d;
        end
    end

    // Next-state logic. Outputs are decoded from the current state only.
    always_comb begin
        state_d     = state;
        bank_sel_d  = bank_sel;
        count_d     = count;
        pollcount_d = pollcount;
        en_snap_d   = en_snap;
        chg_entry_d = 1'b0;
        u_seen_d    = u_seen;
        sweep_end   = 1'b0;
        sel_hit     = '0;
        charge      = 1'b0;
        sense       = 1'b0;
        bank_done   = 1'b0;
        case (state)
            IDLE: begin
                if (m10_tick && poll_r != 4'd0 && bank_en_r != '0) begin
                    if (pollcount == poll_r) begin
                        pollcount_d = 4'd1;
                        en_snap_d   = bank_en_r;
                        sel_hit     = first_set(bank_en_r, 0);
                        bank_sel_d  = sel_hit[BW-1:0];
                        chg_entry_d = 1'b1;
                        u_seen_d    = 1'b0;
                        state_d     = CHARGE;
                    end else begin
                        pollcount_d = pollcount + 4'd1;
                    end
                end
            end
            CHARGE: begin
                charge = 1'b1;
                // Exit on the second u10_tick after entry, so charge lasts 10..20 us.
                if (!chg_entry && u10_tick) begin
                    if (u_seen) begin
                        count_d = '0;
                        state_d = SENSE;
                    end else begin
                        u_seen_d = 1'b1;
                    end
                end
            end
            SENSE: begin
                sense = 1'b1;
                // Early end has priority over a coincident cnt_tick; count holds.
                if (early_r && pins_done) begin
                    state_d = NEXT;
                end else if (cnt_tick) begin
                    if (count == {CW{1'b1}}) state_d = NEXT;
                    else                     count_d = count + 1'b1;
                end
            end
            NEXT: begin
                bank_done = 1'b1;
                // Only banks above the current one; no wrap within a sweep.
                sel_hit = first_set(en_snap, int'(bank_sel) + 1);
                if (sel_hit[BW]) begin
                    bank_sel_d  = sel_hit[BW-1:0];
                    chg_entry_d = 1'b1;
                    u_seen_d    = 1'b0;
                    state_d     = CHARGE;
                end else begin
                    sweep_end = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (cfg_we) pollcount_d = 4'd1;
    end

    // Result flags: a completing sweep beats a coincident rd_ack.
    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            data_avail <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (sweep_end)   data_avail <= 1'b1;
            else if (rd_ack) data_avail <= 1'b0;
            if (cfg_we) overrun <= 1'b0;
            if (sweep_end && data_avail && !rd_ack) overrun <= 1'b1;
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_rcc_sched.sv
// tb_rcc_sched: directed checks of the rcc_sched sweep sequencer.
module tb_rcc_sched;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CHG  = 2'd1;
  localparam logic [1:0] S_SNS  = 2'd2;
  localparam logic [1:0] S_NEXT = 2'd3;

  logic       CLK_I, RSTN_I;
  logic       m10_tick, u10_tick, cnt_tick, cfg_we, cfg_early, pins_done, rd_ack;
  logic [3:0] cfg_poll, cfg_bank_en;
  logic [1:0] bank_sel, state_dbg;
  logic       charge, sense, bank_done, busy, data_avail, overrun;
  logic [7:0] count;

  int checks = 0;
  int errors = 0;

  rcc_sched dut (
    .CLK_I(CLK_I), .RSTN_I(RSTN_I), .m10_tick(m10_tick), .u10_tick(u10_tick),
    .cnt_tick(cnt_tick), .cfg_we(cfg_we), .cfg_poll(cfg_poll), .cfg_bank_en(cfg_bank_en),
    .cfg_early(cfg_early), .pins_done(pins_done), .rd_ack(rd_ack), .bank_sel(bank_sel),
    .charge(charge), .sense(sense), .count(count), .bank_done(bank_done), .busy(busy),
    .data_avail(data_avail), .overrun(overrun), .state_dbg(state_dbg)
  );

  // clock / reset
  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic m10, u10, cnt, we;
    logic [3:0] poll, ben;
    logic early, pd, ack;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs [13];

  function automatic logic [17:0] obs();
    return {state_dbg, bank_sel, charge, sense, count, bank_done, busy, data_avail, overrun};
  endfunction

  // Expected output word; charge/sense/bank_done/busy follow from the state.
  function automatic logic [17:0] e(input logic [1:0] st, input logic [1:0] bs,
                                    input logic [7:0] cnt, input logic da, input logic ov);
    return {st, bs, st == S_CHG, st == S_SNS, cnt, st == S_NEXT, st != S_IDLE, da, ov};
  endfunction

  function automatic vec_t mkv(input logic m10, u10, cnt, we, input logic [3:0] poll, ben,
                               input logic early, pd, ack, input logic [17:0] exp);
    vec_t v;
    v.m10 = m10; v.u10 = u10; v.cnt = cnt; v.we = we; v.poll = poll; v.ben = ben;
    v.early = early; v.pd = pd; v.ack = ack; v.exp = exp;
    return v;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_m10();
    m10_tick = 1'b1; tick(); m10_tick = 1'b0;
  endtask

  task automatic cfg(input logic [3:0] poll, input logic [3:0] ben, input logic early);
    cfg_poll = poll; cfg_bank_en = ben; cfg_early = early; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  // Called in the entry cycle of CHARGE; ends in the first SENSE cycle.
  task automatic do_charge(input logic [1:0] bk, input logic [7:0] cprev, input logic da, input logic ov);
    u10_tick = 1'b0; tick();
    chk("charge_hold", obs(), e(S_CHG, bk, cprev, da, ov));
    u10_tick = 1'b1; tick();
    chk("charge_tick1", obs(), e(S_CHG, bk, cprev, da, ov));
    u10_tick = 1'b1; tick();
    u10_tick = 1'b0;
    chk("sense_start", obs(), e(S_SNS, bk, 8'd0, da, ov));
  endtask

  // Runs cnt_tick from count=start up to saturation, ends in the NEXT cycle.
  task automatic finish_bank(input int start, input logic [1:0] bk, input logic da, input logic ov);
    cnt_tick = 1'b1;
    repeat (255 - start) tick();
    chk("count_255", obs(), e(S_SNS, bk, 8'd255, da, ov));
    tick();
    cnt_tick = 1'b0;
    chk("bank_done_sat", obs(), e(S_NEXT, bk, 8'd255, da, ov));
  endtask

  initial begin
    int hi;
    RSTN_I = 1'b0; m10_tick = 0; u10_tick = 0; cnt_tick = 0; cfg_we = 0;
    cfg_poll = 0; cfg_bank_en = 0; cfg_early = 0; pins_done = 0; rd_ack = 0;
    repeat (3) tick();
    chk("reset_state", obs(), e(S_IDLE, 2'd0, 8'd0, 1'b0, 1'b0));
    RSTN_I = 1'b1;
    tick();

    // Table: config poll=2 bank_en=0101, first sweep start and charge/sense entry.
    vecs[0]  = mkv(0,0,0,1, 4'd2,4'b0101, 0,0,0, e(S_IDLE, 2'd0, 8'd0, 0, 0));
    vecs[1]  = mkv(1,0,0,0, 4'd2,4'b0101, 0,0,0, e(S_IDLE, 2'd0, 8'd0, 0, 0));
    vecs[2]  = mkv(0,0,0,0, 4'd2,4'b0101, 0,0,0, e(S_IDLE, 2'd0, 8'd0, 0, 0));
    vecs[3]  = mkv(1,0,0,0, 4'd2,4'b0101, 0,0,0, e(S_CHG,  2'd0, 8'd0, 0, 0));
    vecs[4]  = mkv(0,1,0,0, 4'd2,4'b0101, 0,0,0, e(S_CHG,  2'd0, 8'd0, 0, 0));
    vecs[5]  = mkv(0,1,0,0, 4'd2,4'b0101, 0,0,0, e(S_CHG,  2'd0, 8'd0, 0, 0));
    vecs[6]  = mkv(0,0,0,0, 4'd2,4'b0101, 0,0,0, e(S_CHG,  2'd0, 8'd0, 0, 0));
    vecs[7]  = mkv(1,0,0,0, 4'd2,4'b0101, 0,0,0, e(S_CHG,  2'd0, 8'd0, 0, 0));
    vecs[8]  = mkv(0,1,0,0, 4'd2,4'b0101, 0,0,0, e(S_SNS,  2'd0, 8'd0, 0, 0));
    vecs[9]  = mkv(0,0,1,0, 4'd2,4'b0101, 0,0,0, e(S_SNS,  2'd0, 8'd1, 0, 0));
    vecs[10] = mkv(0,0,0,0, 4'd2,4'b0101, 0,0,0, e(S_SNS,  2'd0, 8'd1, 0, 0));
    vecs[11] = mkv(0,0,1,0, 4'd2,4'b0101, 0,0,0, e(S_SNS,  2'd0, 8'd2, 0, 0));
    vecs[12] = mkv(0,0,1,0, 4'd2,4'b0101, 0,1,0, e(S_SNS,  2'd0, 8'd3, 0, 0));
    for (int i = 0; i < 13; i++) begin
      m10_tick = vecs[i].m10; u10_tick = vecs[i].u10; cnt_tick = vecs[i].cnt;
      cfg_we = vecs[i].we; cfg_poll = vecs[i].poll; cfg_bank_en = vecs[i].ben;
      cfg_early = vecs[i].early; pins_done = vecs[i].pd; rd_ack = vecs[i].ack;
      tick();
      chk($sformatf("vec%0d", i), obs(), vecs[i].exp);
    end
    m10_tick = 0; u10_tick = 0; cnt_tick = 0; cfg_we = 0; pins_done = 0; rd_ack = 0;

    // Sweep 1: finish bank 0, then bank 2, then data_avail.
    finish_bank(3, 2'd0, 0, 0);
    tick();
    chk("next_bank2", obs(), e(S_CHG, 2'd2, 8'd255, 0, 0));
    do_charge(2'd2, 8'd255, 0, 0);
    finish_bank(0, 2'd2, 0, 0);
    tick();
    chk("sweep1_done", obs(), e(S_IDLE, 2'd2, 8'd255, 1, 0));

    // m10 during CHARGE did not advance pollcount: start needs two more ticks.
    pulse_m10();
    chk("poll_wait", obs(), e(S_IDLE, 2'd2, 8'd255, 1, 0));
    pulse_m10();
    chk("sweep2_start", obs(), e(S_CHG, 2'd0, 8'd255, 1, 0));
    do_charge(2'd0, 8'd255, 1, 0);
    finish_bank(0, 2'd0, 1, 0);
    tick();
    do_charge(2'd2, 8'd255, 1, 0);
    finish_bank(0, 2'd2, 1, 0);
    tick();
    chk("overrun_set", obs(), e(S_IDLE, 2'd2, 8'd255, 1, 1));
    repeat (5) tick();
    chk("overrun_sticky", obs(), e(S_IDLE, 2'd2, 8'd255, 1, 1));
    cfg(4'd2, 4'b0101, 1'b0);
    chk("overrun_clr", obs(), e(S_IDLE, 2'd2, 8'd255, 1, 0));

    // Sweep 3: rd_ack coincides with completion, set wins, no overrun.
    pulse_m10();
    pulse_m10();
    chk("sweep3_start", obs(), e(S_CHG, 2'd0, 8'd255, 1, 0));
    do_charge(2'd0, 8'd255, 1, 0);
    finish_bank(0, 2'd0, 1, 0);
    tick();
    do_charge(2'd2, 8'd255, 1, 0);
    finish_bank(0, 2'd2, 1, 0);
    rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    chk("ack_vs_set", obs(), e(S_IDLE, 2'd2, 8'd255, 1, 0));
    rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    chk("ack_clear", obs(), e(S_IDLE, 2'd2, 8'd255, 0, 0));

    // Early end on bank 1, with charge timing: u10 at entry, +1000, +2000.
    cfg(4'd1, 4'b0010, 1'b1);
    pulse_m10();
    chk("early_start", obs(), e(S_CHG, 2'd1, 8'd255, 0, 0));
    hi = 1;
    for (int k = 0; k <= 2000; k++) begin
      u10_tick = (k == 0 || k == 1000 || k == 2000);
      tick();
      if (charge) hi++;
    end
    u10_tick = 1'b0;
    chk("charge_cycles", hi, 2001);
    chk("charge_exit", obs(), e(S_SNS, 2'd1, 8'd0, 0, 0));
    cnt_tick = 1'b1;
    repeat (37) tick();
    chk("count_37", obs(), e(S_SNS, 2'd1, 8'd37, 0, 0));
    pins_done = 1'b1; tick();
    cnt_tick = 1'b0; pins_done = 1'b0;
    chk("early_done", obs(), e(S_NEXT, 2'd1, 8'd37, 0, 0));
    tick();
    chk("early_sweep_end", obs(), e(S_IDLE, 2'd1, 8'd37, 1, 0));

    // Mid-sweep config write: sweep completes on the snapshot, then stops.
    rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    cfg(4'd1, 4'b0101, 1'b0);
    pulse_m10();
    chk("mid_start", obs(), e(S_CHG, 2'd0, 8'd37, 0, 0));
    do_charge(2'd0, 8'd37, 0, 0);
    cnt_tick = 1'b1;
    repeat (10) tick();
    cfg_poll = 4'd0; cfg_bank_en = 4'b0001; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    chk("mid_cfg", obs(), e(S_SNS, 2'd0, 8'd11, 0, 0));
    finish_bank(11, 2'd0, 0, 0);
    tick();
    chk("mid_bank2", obs(), e(S_CHG, 2'd2, 8'd255, 0, 0));
    do_charge(2'd2, 8'd255, 0, 0);
    finish_bank(0, 2'd2, 0, 0);
    tick();
    chk("mid_done", obs(), e(S_IDLE, 2'd2, 8'd255, 1, 0));
    for (int i = 0; i < 3; i++) begin
      pulse_m10();
      chk("poll_off", obs(), e(S_IDLE, 2'd2, 8'd255, 1, 0));
    end

    // Async reset during CHARGE.
    cfg(4'd1, 4'b0001, 1'b0);
    pulse_m10();
    chk("rst_pre", obs(), e(S_CHG, 2'd0, 8'd255, 1, 0));
    #2;
    RSTN_I = 1'b0;
    #1;
    chk("rst_async_charge", {charge, busy}, 2'b00);
    chk("rst_async_all", obs(), e(S_IDLE, 2'd0, 8'd0, 0, 0));
    tick();
    RSTN_I = 1'b1;
    tick();
    pulse_m10();
    chk("rst_cfg_clear", obs(), e(S_IDLE, 2'd0, 8'd0, 0, 0));
    cfg(4'd2, 4'b1000, 1'b0);
    pulse_m10();
    chk("rst_poll1", obs(), e(S_IDLE, 2'd0, 8'd0, 0, 0));
    pulse_m10();
    chk("rst_poll2", obs(), e(S_CHG, 2'd3, 8'd0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
